// File: rtl/spart_rx_param.sv
// Oversampling UART receiver: 2-flop input synchroniser, per-frame baud tick generator,
// 3-sample majority vote, glitch-rejecting start detect and a valid/ready holding register.
module spart_rx_param #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic [1:0]           br_cfg,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int DIV_4800  = (CLK_FREQ + (4800  * OVERSAMPLE) / 2) / (4800  * OVERSAMPLE);
  localparam int DIV_9600  = (CLK_FREQ + (9600  * OVERSAMPLE) / 2) / (9600  * OVERSAMPLE);
  localparam int DIV_19200 = (CLK_FREQ + (19200 * OVERSAMPLE) / 2) / (19200 * OVERSAMPLE);
  localparam int DIV_38400 = (CLK_FREQ + (38400 * OVERSAMPLE) / 2) / (38400 * OVERSAMPLE);

  localparam int CNT_W = $clog2(DIV_4800 + 1);
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [OS_W-1:0]  OS_S0   = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  OS_S1   = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0]  OS_S2   = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_rxsPrev;
  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_tickCnt;
  logic [CNT_W-1:0]     r_divM1;
  logic [OS_W-1:0]      r_osCnt;
  logic                 r_s0;
  logic                 r_s1;
  logic [BIT_W-1:0]     r_bitCnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parErrPend;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frameErr;
  logic                 r_parityErr;
  logic                 r_overrun;

  logic [CNT_W-1:0] w_divSel;
  logic             w_rxs;
  logic             w_startEdge;
  logic             w_tick;
  logic             w_vote;
  logic             w_voteTick;
  logic             w_bitEnd;
  logic             w_deliver;
  logic             w_expPar;
  logic             w_parityOn;

  always_comb begin
    w_divSel = CNT_W'(DIV_4800 - 1);
    case (br_cfg)
      2'b01:   w_divSel = CNT_W'(DIV_9600 - 1);
      2'b10:   w_divSel = CNT_W'(DIV_19200 - 1);
      2'b11:   w_divSel = CNT_W'(DIV_38400 - 1);
      default: w_divSel = CNT_W'(DIV_4800 - 1);
    endcase
  end

  assign w_rxs       = r_sync2;
  assign w_parityOn  = (PARITY_EN != 0);
  assign w_startEdge = (r_state == S_IDLE) && r_rxsPrev && !w_rxs;
  assign w_tick      = (r_state != S_IDLE) && (r_tickCnt == '0);
  assign w_vote      = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
  assign w_voteTick  = w_tick && (r_osCnt == OS_S2);
  assign w_bitEnd    = w_tick && (r_osCnt == OS_LAST);
  assign w_deliver   = (r_state == S_STOP) && w_voteTick;
  assign w_expPar    = (^r_shift) ^ (PARITY_ODD != 0);

  // Flops preset to idle-high so a reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rxsPrev <= 1'b1;
    end else begin
      r_sync1   <= rxd;
      r_sync2   <= r_sync1;
      r_rxsPrev <= r_sync2;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_tickCnt    <= '0;
      r_divM1      <= '0;
      r_osCnt      <= '0;
      r_s0         <= 1'b0;
      r_s1         <= 1'b0;
      r_bitCnt     <= '0;
      r_shift      <= '0;
      r_parErrPend <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_divM1 <= w_divSel;
      if (w_startEdge) begin
        r_state      <= S_START;
        r_tickCnt    <= w_divSel;
        r_osCnt      <= '0;
        r_bitCnt     <= '0;
        r_parErrPend <= 1'b0;
      end
    end else begin
      r_tickCnt <= (r_tickCnt == '0) ? r_divM1 : r_tickCnt - CNT_W'(1);
      if (w_tick) begin
        r_osCnt <= (r_osCnt == OS_LAST) ? '0 : r_osCnt + OS_W'(1);
        if (r_osCnt == OS_S0) r_s0 <= w_rxs;
        if (r_osCnt == OS_S1) r_s1 <= w_rxs;
      end
      case (r_state)
        S_START: begin
          if (w_voteTick && w_vote) r_state <= S_IDLE;
          else if (w_bitEnd)        r_state <= S_DATA;
        end
        S_DATA: begin
          if (w_voteTick) r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
          if (w_bitEnd) begin
            if (r_bitCnt == BIT_LAST) begin
              r_bitCnt <= '0;
              r_state  <= w_parityOn ? S_PARITY : S_STOP;
            end else begin
              r_bitCnt <= r_bitCnt + BIT_W'(1);
            end
          end
        end
        S_PARITY: begin
          if (w_voteTick && (w_vote != w_expPar)) r_parErrPend <= 1'b1;
          if (w_bitEnd) r_state <= S_STOP;
        end
        // Leave at the mid-stop sample so a back-to-back start edge is not missed.
        S_STOP: begin
          if (w_voteTick) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frameErr  <= 1'b0;
      r_parityErr <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_deliver) begin
        if (!r_valid || rx_ready) begin
          r_data      <= r_shift;
          r_frameErr  <= ~w_vote;
          r_parityErr <= w_parityOn & r_parErrPend;
          r_valid     <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (rx_ready && r_valid) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign frame_err  = r_frameErr;
  assign parity_err = w_parityOn & r_parityErr;
  assign overrun    = r_overrun;

endmodule
